csr_uart: RTL

// - Hardware UART for the Pipeline CSR port at 0xbc0: CSR write queues a byte, CSR read polls status/RX byte.
// - Sits beside CsrCounter; its valid is ORed into Pipeline csr_valid, rdata into csr_rdata.
// - TX FIFO feeds an 8N1 serializer, so software can issue bursts without polling per byte.

---
 rtl/csr_uart.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_uart.sv
// csr_uart: CSR-mapped UART. A CSR write queues a TX byte into a small FIFO feeding an 8N1 serializer.
// A CSR read returns a status snapshot. Define CSR_UART_RX_EN to build the optional receive path.
module csr_uart #(
    parameter logic [11:0] CSR_ADDR = 12'hbc0,
    parameter int unsigned DIVISOR  = 868,
    parameter int unsigned FIFO_LOG = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    output logic        tx,
    input  logic        rx
);
    localparam int unsigned DEPTH  = 2 ** FIFO_LOG;
    localparam int unsigned CW     = FIFO_LOG + 1;
    localparam logic [15:0] DIV_M1 = 16'(DIVISOR - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic hit_rd, hit_wr, hit;
    assign hit_rd = (addr == CSR_ADDR) && read;
    assign hit_wr = (addr == CSR_ADDR) && (modify == 3'd1);
    assign hit    = hit_rd || hit_wr;

    logic [7:0]          mem [DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic                empty, full, pop, push, drop;

    // A pop in the same cycle frees the slot, so a write on a full FIFO is only dropped without one.
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign push  = hit_wr && (!full || pop);
    assign drop  = hit_wr && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_LOG'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_LOG'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    state_t      tx_state, tx_state_d;
    logic [15:0] tx_cnt, tx_cnt_d;
    logic [2:0]  tx_bit, tx_bit_d;
    logic [7:0]  tx_shift, tx_shift_d;
    logic        tx_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tx_state <= IDLE;
        else       tx_state <= tx_state_d;
    end

    // TX next state; tx is registered from the next state so the start bit follows the pop by one cycle.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        pop        = 1'b0;
        case (tx_state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    tx_shift_d = mem[rd_ptr];
                    tx_cnt_d   = DIV_M1;
                    tx_state_d = START;
                end
            end
            START: begin
                if (tx_cnt == '0) begin
                    tx_cnt_d   = DIV_M1;
                    tx_bit_d   = '0;
                    tx_state_d = DATA;
                end else begin
                    tx_cnt_d = tx_cnt - 16'd1;
                end
            end
            DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_d   = DIV_M1;
                    tx_bit_d   = tx_bit + 3'd1;
                    tx_shift_d = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_state_d = STOP;
                end else begin
                    tx_cnt_d = tx_cnt - 16'd1;
                end
            end
            STOP: begin
                if (tx_cnt == '0) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        tx_shift_d = mem[rd_ptr];
                        tx_cnt_d   = DIV_M1;
                        tx_state_d = START;
                    end else begin
                        tx_state_d = IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt - 16'd1;
                end
            end
            default: tx_state_d = IDLE;
        endcase
        tx_d = (tx_state_d == START) ? 1'b0 :
               (tx_state_d == DATA)  ? tx_shift_d[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx       <= tx_d;
        end
    end

    logic [7:0] rx_byte;
    logic       rx_valid, rx_overrun, unused_bits;

`ifdef CSR_UART_RX_EN
    localparam logic [15:0] HALF_M1 = 16'(DIVISOR / 2 - 1);

    logic [2:0]  rx_sync;
    state_t      rx_state, rx_state_d;
    logic [15:0] rx_cnt, rx_cnt_d;
    logic [2:0]  rx_bit, rx_bit_d;
    logic [7:0]  rx_shift, rx_shift_d;
    logic        rx_s, rx_fall, rx_done;

    // rx_sync[1:0] is the synchronizer, rx_sync[2] the previous synchronized value for edge detection.
    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_sync[2] && !rx_sync[1];
    assign unused_bits = ^wdata[31:8];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rx_state <= IDLE;
        else       rx_state <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_done    = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_fall) begin
                    rx_cnt_d   = HALF_M1;
                    rx_state_d = START;
                end
            end
            START: begin
                if (rx_cnt == '0) begin
                    rx_cnt_d   = DIV_M1;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? IDLE : DATA;
                end else begin
                    rx_cnt_d = rx_cnt - 16'd1;
                end
            end
            DATA: begin
                if (rx_cnt == '0) begin
                    rx_cnt_d   = DIV_M1;
                    rx_bit_d   = rx_bit + 3'd1;
                    rx_shift_d = {rx_s, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_d = STOP;
                end else begin
                    rx_cnt_d = rx_cnt - 16'd1;
                end
            end
            STOP: begin
                if (rx_cnt == '0) begin
                    rx_done    = rx_s;
                    rx_state_d = IDLE;
                end else begin
                    rx_cnt_d = rx_cnt - 16'd1;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // A completing byte wins over a clearing read; overrun only when the old byte was never read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_sync    <= 3'b111;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_sync    <= {rx_sync[1:0], rx};
            rx_cnt     <= rx_cnt_d;
            rx_bit     <= rx_bit_d;
            rx_shift   <= rx_shift_d;
            if (rx_done) rx_byte <= rx_shift;
            rx_valid   <= rx_done || (rx_valid && !hit_rd);
            rx_overrun <= (rx_overrun && !hit_rd) || (rx_done && rx_valid && !hit_rd);
        end
    end
`else
    assign rx_byte     = '0;
    assign rx_valid    = 1'b0;
    assign rx_overrun  = 1'b0;
    assign unused_bits = ^{wdata[31:8], rx};
`endif

    logic        tx_drop, tx_idle;
    logic [31:0] status;
    assign tx_idle = empty && (tx_state == IDLE);
    assign status  = {19'b0, tx_drop, rx_overrun, tx_idle, full, rx_valid, rx_byte};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid   <= 1'b0;
            rdata   <= '0;
            tx_drop <= 1'b0;
        end else begin
            valid   <= hit;
            rdata   <= hit ? status : '0;
            tx_drop <= (tx_drop && !hit_rd) || drop;
        end
    end
endmodule
